// File: rtl/floo_pkg.sv
// Shared constants and helpers for the FlooNoC link pipeline: channel indices,
// default flit payload type and the stall-injection LFSR step.
package floo_pkg;

  localparam int unsigned NarrowReq       = 0;
  localparam int unsigned NarrowRsp       = 1;
  localparam int unsigned Wide            = 2;
  localparam int unsigned NumLinkChannels = 3;

  localparam int unsigned CntWidth        = 32;
  localparam logic [15:0] DefaultLfsrSeed = 16'hACE1;

  typedef logic [63:0] flit_t;

  // Fibonacci LFSR, taps 16,14,13,11 (bit indices 15,13,12,10), shifting left.
  function automatic logic [15:0] lfsr_next(input logic [15:0] state);
    return {state[14:0], state[15] ^ state[13] ^ state[12] ^ state[10]};
  endfunction

endpackage

// File: rtl/floo_link_stage.sv
// One fully-decoupled 2-entry buffer: registered valid_o and ready_o, so no
// combinational path crosses the stage in either direction.
module floo_link_stage #(
  parameter type flit_t = logic [63:0]
) (
  input  logic  clk_i,
  input  logic  rst_ni,
  input  logic  valid_i,
  output logic  ready_o,
  input  flit_t data_i,
  output logic  valid_o,
  input  logic  ready_i,
  output flit_t data_o
);

  flit_t main_q, skid_q;
  logic  main_vld_q, skid_vld_q;
  logic  push, pop;

  assign ready_o = ~skid_vld_q;
  assign valid_o = main_vld_q;
  assign data_o  = main_q;
  assign push    = valid_i & ready_o;
  assign pop     = main_vld_q & ready_i;

  // NOTE: payload registers are reset too, so a mid-transfer reset can never
  // expose stale or X data; all state updates use non-blocking assignments.
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      main_q     <= '0;
      skid_q     <= '0;
      main_vld_q <= 1'b0;
      skid_vld_q <= 1'b0;
    end else if (pop) begin
      // While the skid entry is full ready_o is low, so push cannot coincide.
      if (skid_vld_q) begin
        main_q     <= skid_q;
        skid_vld_q <= 1'b0;
      end else if (push) begin
        main_q     <= data_i;
      end else begin
        main_vld_q <= 1'b0;
      end
    end else if (push) begin
      if (!main_vld_q) begin
        main_q     <= data_i;
        main_vld_q <= 1'b1;
      end else begin
        skid_q     <= data_i;
        skid_vld_q <= 1'b1;
      end
    end
  end

endmodule

// File: rtl/floo_link_pipe.sv
// Multi-channel link pipeline: Depth decoupled stages per channel, per-channel
// pseudo-random output stall injection and 32-bit handshake counters.
module floo_link_pipe #(
  parameter int unsigned NumChannels = floo_pkg::NumLinkChannels,
  parameter int unsigned Depth       = 2,
  parameter type         flit_t      = floo_pkg::flit_t,
  parameter logic [15:0] LfsrSeed    = floo_pkg::DefaultLfsrSeed
) (
  input  logic                                            clk_i,
  input  logic                                            rst_ni,
  input  logic                                            stall_en_i,
  input  logic                                            cnt_clr_i,
  input  logic  [NumChannels-1:0]                         valid_i,
  output logic  [NumChannels-1:0]                         ready_o,
  input  flit_t [NumChannels-1:0]                         data_i,
  output logic  [NumChannels-1:0]                         valid_o,
  input  logic  [NumChannels-1:0]                         ready_i,
  output flit_t [NumChannels-1:0]                         data_o,
  output logic  [NumChannels-1:0][floo_pkg::CntWidth-1:0] flit_cnt_o
);

  for (genvar c = 0; c < NumChannels; c++) begin : gen_ch
    localparam logic [15:0] Seed = LfsrSeed ^ 16'(c);

    logic  [Depth:0]               vld, rdy;
    flit_t [Depth:0]               dat;
    logic  [15:0]                  lfsr_q;
    logic                          held_q, block, hs;
    logic  [floo_pkg::CntWidth-1:0] cnt_q, cnt_d;

    assign vld[0]     = valid_i[c];
    assign dat[0]     = data_i[c];
    assign ready_o[c] = rdy[0];

    for (genvar s = 0; s < Depth; s++) begin : gen_stage
      floo_link_stage #(.flit_t(flit_t)) u_stage (
        .clk_i   (clk_i),
        .rst_ni  (rst_ni),
        .valid_i (vld[s]),
        .ready_o (rdy[s]),
        .data_i  (dat[s]),
        .valid_o (vld[s+1]),
        .ready_i (rdy[s+1]),
        .data_o  (dat[s+1])
      );
    end

    // Stall only suppresses a new valid; an already offered flit is held, and
    // the same gate on ready keeps the Depth=0 pass-through consistent.
    assign block      = stall_en_i & lfsr_q[0] & ~held_q;
    assign valid_o[c] = vld[Depth] & ~block;
    assign rdy[Depth] = ready_i[c] & ~block;
    assign data_o[c]  = dat[Depth];
    assign hs         = valid_o[c] & ready_i[c];

    assign cnt_d         = cnt_clr_i ? {{(floo_pkg::CntWidth-1){1'b0}}, hs}
                                     : cnt_q + floo_pkg::CntWidth'(hs);
    assign flit_cnt_o[c] = cnt_q;

    always_ff @(posedge clk_i or negedge rst_ni) begin
      if (!rst_ni) begin
        lfsr_q <= Seed;
        held_q <= 1'b0;
        cnt_q  <= '0;
      end else begin
        lfsr_q <= floo_pkg::lfsr_next(lfsr_q);
        held_q <= valid_o[c] & ~ready_i[c];
        cnt_q  <= cnt_d;
      end
    end
  end

endmodule

// File: tb/tb_floo_link_pipe.sv
// Self-checking bench for floo_link_pipe: queue scoreboard per channel plus
// directed latency, throughput, backpressure, counter and reset scenarios.
module tb_floo_link_pipe;

  localparam int          NCH   = 3;
  localparam int          DEPTH = 2;
  localparam logic [15:0] SEED  = 16'hACE1;

  logic                      clk = 1'b0;
  logic                      rst_n;
  logic                      stall_en, cnt_clr;
  logic [NCH-1:0]            up_valid, up_ready, dn_valid, dn_ready;
  logic [NCH-1:0][63:0]      up_data, dn_data;
  logic [NCH-1:0][31:0]      flit_cnt;

  always #5 clk = ~clk;

  floo_link_pipe #(
    .NumChannels (NCH),
    .Depth       (DEPTH),
    .flit_t      (logic [63:0]),
    .LfsrSeed    (SEED)
  ) dut (
    .clk_i      (clk),
    .rst_ni     (rst_n),
    .stall_en_i (stall_en),
    .cnt_clr_i  (cnt_clr),
    .valid_i    (up_valid),
    .ready_o    (up_ready),
    .data_i     (up_data),
    .valid_o    (dn_valid),
    .ready_i    (dn_ready),
    .data_o     (dn_data),
    .flit_cnt_o (flit_cnt)
  );

  int          n_cmp = 0;
  int          n_err = 0;
  logic [63:0] exp_q [NCH][$];
  logic [31:0] exp_cnt [NCH];
  logic [15:0] ref_lfsr [NCH];
  logic        prev_v [NCH];
  logic        prev_r [NCH];
  logic [63:0] prev_d [NCH];
  logic [NCH-1:0] s_in_hs, s_out_hs, s_valid;

  function automatic logic [15:0] lfsr_step(input logic [15:0] s);
    return {s[14:0], s[15] ^ s[13] ^ s[12] ^ s[10]};
  endfunction

  task automatic model_reset();
    for (int c = 0; c < NCH; c++) begin
      exp_q[c].delete();
      exp_cnt[c]  = '0;
      ref_lfsr[c] = SEED ^ 16'(c);
      prev_v[c]   = 1'b0;
      prev_r[c]   = 1'b0;
      prev_d[c]   = '0;
    end
  endtask

  // One clock cycle: sample at negedge, score against the reference, then
  // advance the reference state at the posedge and return 1 time unit later.
  task automatic cycle();
    logic [63:0] want;
    @(negedge clk);
    s_valid = dn_valid;
    for (int c = 0; c < NCH; c++) begin
      s_in_hs[c]  = up_valid[c] & up_ready[c];
      s_out_hs[c] = dn_valid[c] & dn_ready[c];
      if (s_in_hs[c]) exp_q[c].push_back(up_data[c]);
      if (prev_v[c] && !prev_r[c]) begin
        n_cmp++;
        if (dn_valid[c] !== 1'b1 || dn_data[c] !== prev_d[c]) begin
          n_err++;
          $display("FAIL hold ch%0d: valid=%b data=%h, required valid=1 data=%h",
                   c, dn_valid[c], dn_data[c], prev_d[c]);
        end
      end else if (stall_en && ref_lfsr[c][0]) begin
        n_cmp++;
        if (dn_valid[c] !== 1'b0) begin
          n_err++;
          $display("FAIL stall ch%0d: valid=%b, required 0", c, dn_valid[c]);
        end
      end
      if (s_out_hs[c]) begin
        n_cmp++;
        if (exp_q[c].size() == 0) begin
          n_err++;
          $display("FAIL spurious ch%0d: got flit %h, required none", c, dn_data[c]);
        end else begin
          want = exp_q[c].pop_front();
          if (dn_data[c] !== want) begin
            n_err++;
            $display("FAIL order ch%0d: got %h, required %h", c, dn_data[c], want);
          end
        end
      end
      n_cmp++;
      if (flit_cnt[c] !== exp_cnt[c]) begin
        n_err++;
        $display("FAIL count ch%0d: got %h, required %h", c, flit_cnt[c], exp_cnt[c]);
      end
      prev_v[c] = dn_valid[c];
      prev_r[c] = dn_ready[c];
      prev_d[c] = dn_data[c];
    end
    @(posedge clk);
    for (int c = 0; c < NCH; c++) begin
      if (cnt_clr) exp_cnt[c] = {31'd0, s_out_hs[c]};
      else         exp_cnt[c] = exp_cnt[c] + {31'd0, s_out_hs[c]};
      ref_lfsr[c] = lfsr_step(ref_lfsr[c]);
    end
    #1;
  endtask

  task automatic idle_inputs();
    up_valid = '0;
    up_data  = '0;
    dn_ready = '1;
    stall_en = 1'b0;
    cnt_clr  = 1'b0;
  endtask

  task automatic drain_check(input string name);
    up_valid = '0;
    dn_ready = '1;
    repeat (DEPTH * 2 + 20) cycle();
    for (int c = 0; c < NCH; c++) begin
      n_cmp++;
      if (exp_q[c].size() != 0) begin
        n_err++;
        $display("FAIL %s_drain ch%0d: %0d flits left, required 0", name, c, exp_q[c].size());
      end
    end
  endtask

  task automatic test_reset();
    rst_n = 1'b0;
    idle_inputs();
    repeat (2) @(posedge clk);
    #1;
    for (int c = 0; c < NCH; c++) begin
      n_cmp++;
      if (dn_valid[c] !== 1'b0 || up_ready[c] !== 1'b1 || flit_cnt[c] !== 32'd0) begin
        n_err++;
        $display("FAIL reset ch%0d: valid=%b ready=%b cnt=%h, required 0/1/0",
                 c, dn_valid[c], up_ready[c], flit_cnt[c]);
      end
    end
    rst_n = 1'b1;
    model_reset();
    repeat (3) cycle();
  endtask

  task automatic test_latency();
    int lat = -1;
    cnt_clr = 1'b1;
    cycle();
    cnt_clr = 1'b0;
    up_valid[0] = 1'b1;
    up_data[0]  = 64'h1;
    for (int k = 0; k < DEPTH + 4; k++) begin
      cycle();
      if (s_valid[0] && lat < 0) lat = k;
      up_valid = '0;
    end
    n_cmp++;
    if (lat != DEPTH) begin
      n_err++;
      $display("FAIL latency: got %0d cycles, required %0d", lat, DEPTH);
    end
    n_cmp++;
    if (flit_cnt[0] !== 32'd1) begin
      n_err++;
      $display("FAIL latency_cnt: got %0d, required 1", flit_cnt[0]);
    end
  endtask

  task automatic test_back_to_back();
    localparam int N = 1000;
    int k = 0, last = -1, refused = 0;
    int outs [NCH];
    cnt_clr = 1'b1;
    cycle();
    cnt_clr = 1'b0;
    for (int c = 0; c < NCH; c++) outs[c] = 0;
    while (k < N + DEPTH + 20) begin
      for (int c = 0; c < NCH; c++) begin
        up_valid[c] = (k < N);
        up_data[c]  = {$urandom, $urandom};
      end
      cycle();
      if (k < N && s_in_hs != '1) refused++;
      for (int c = 0; c < NCH; c++) if (s_out_hs[c]) outs[c]++;
      if (s_out_hs != '0) last = k;
      k++;
    end
    n_cmp++;
    if (refused != 0) begin
      n_err++;
      $display("FAIL b2b_ready: %0d refused cycles, required 0", refused);
    end
    n_cmp++;
    if (last != N - 1 + DEPTH) begin
      n_err++;
      $display("FAIL b2b_cycles: last output at cycle %0d, required %0d", last, N - 1 + DEPTH);
    end
    for (int c = 0; c < NCH; c++) begin
      n_cmp++;
      if (outs[c] != N || flit_cnt[c] !== 32'(N)) begin
        n_err++;
        $display("FAIL b2b_total ch%0d: out=%0d cnt=%0d, required %0d", c, outs[c], flit_cnt[c], N);
      end
    end
  endtask

  task automatic test_backpressure();
    int acc [NCH];
    int low0or2 = 0;
    for (int c = 0; c < NCH; c++) acc[c] = 0;
    dn_ready = 3'b101;
    for (int c = 0; c < NCH; c++) begin
      up_valid[c] = 1'b1;
      up_data[c]  = {$urandom, $urandom};
    end
    repeat (10) begin
      if (!up_ready[0] || !up_ready[2]) low0or2++;
      cycle();
      for (int c = 0; c < NCH; c++) begin
        if (s_in_hs[c]) begin
          acc[c]++;
          up_data[c] = {$urandom, $urandom};
        end
      end
    end
    n_cmp++;
    if (acc[1] != 2 * DEPTH || up_ready[1] !== 1'b0) begin
      n_err++;
      $display("FAIL bp_ch1: accepted %0d ready=%b, required %0d and 0", acc[1], up_ready[1], 2 * DEPTH);
    end
    n_cmp++;
    if (acc[0] != 10 || acc[2] != 10 || low0or2 != 0) begin
      n_err++;
      $display("FAIL bp_others: ch0=%0d ch2=%0d low=%0d, required 10/10/0", acc[0], acc[2], low0or2);
    end
    drain_check("bp");
  endtask

  task automatic test_stall_random();
    int total = 0, cyc = 0;
    stall_en = 1'b1;
    up_valid = '0;
    while (total < 10000 && cyc < 40000) begin
      for (int c = 0; c < NCH; c++) begin
        if (!(up_valid[c] && !s_in_hs[c])) begin
          up_valid[c] = ($urandom_range(0, 3) != 0);
          up_data[c]  = {$urandom, $urandom};
        end
        dn_ready[c] = ($urandom_range(0, 3) != 0);
      end
      cycle();
      for (int c = 0; c < NCH; c++) if (s_in_hs[c]) total++;
      cyc++;
    end
    n_cmp++;
    if (total < 10000) begin
      n_err++;
      $display("FAIL stall_budget: %0d flits accepted, required 10000", total);
    end
    up_valid = '0;
    dn_ready = '1;
    repeat (200) cycle();
    stall_en = 1'b0;
    drain_check("stall");
  endtask

  task automatic test_counter();
    force dut.gen_ch[0].cnt_d = 32'hFFFF_FFFF;
    cycle();
    release dut.gen_ch[0].cnt_d;
    exp_cnt[0] = 32'hFFFF_FFFF;
    n_cmp++;
    if (flit_cnt[0] !== 32'hFFFF_FFFF) begin
      n_err++;
      $display("FAIL cnt_preload: got %h, required ffffffff", flit_cnt[0]);
    end
    up_valid[0] = 1'b1;
    up_data[0]  = {$urandom, $urandom};
    cycle();
    up_valid = '0;
    repeat (DEPTH) cycle();
    n_cmp++;
    if (flit_cnt[0] !== 32'd0) begin
      n_err++;
      $display("FAIL cnt_wrap: got %h, required 0", flit_cnt[0]);
    end
    up_valid[0] = 1'b1;
    up_data[0]  = {$urandom, $urandom};
    cycle();
    up_valid = '0;
    repeat (DEPTH - 1) cycle();
    cnt_clr = 1'b1;
    cycle();
    cnt_clr = 1'b0;
    n_cmp++;
    if (s_out_hs[0] !== 1'b1 || flit_cnt[0] !== 32'd1) begin
      n_err++;
      $display("FAIL cnt_clr_hs: hs=%b cnt=%h, required 1 and 1", s_out_hs[0], flit_cnt[0]);
    end
    n_cmp++;
    if (flit_cnt[1] !== 32'd0 || flit_cnt[2] !== 32'd0) begin
      n_err++;
      $display("FAIL cnt_clr_only: ch1=%h ch2=%h, required 0", flit_cnt[1], flit_cnt[2]);
    end
  endtask

  task automatic test_reset_mid();
    int outs = 0;
    dn_ready = '0;
    up_valid = '1;
    repeat (3) begin
      for (int c = 0; c < NCH; c++) up_data[c] = {$urandom, $urandom};
      cycle();
    end
    up_valid = '0;
    cycle();
    n_cmp++;
    if (dn_valid !== '1) begin
      n_err++;
      $display("FAIL rmid_pre: valid=%b, required 111", dn_valid);
    end
    #2 rst_n = 1'b0;
    #1;
    n_cmp++;
    if (dn_valid !== '0 || up_ready !== '1) begin
      n_err++;
      $display("FAIL rmid_async: valid=%b ready=%b, required 000/111", dn_valid, up_ready);
    end
    @(posedge clk);
    @(posedge clk);
    #1;
    dn_ready = '1;
    rst_n    = 1'b1;
    model_reset();
    repeat (10) begin
      cycle();
      if (s_valid != '0) outs++;
    end
    n_cmp++;
    if (outs != 0) begin
      n_err++;
      $display("FAIL rmid_leak: %0d cycles with valid, required 0", outs);
    end
    for (int c = 0; c < NCH; c++) begin
      n_cmp++;
      if (flit_cnt[c] !== 32'd0) begin
        n_err++;
        $display("FAIL rmid_cnt ch%0d: got %h, required 0", c, flit_cnt[c]);
      end
    end
  endtask

  initial begin
    s_in_hs  = '0;
    s_out_hs = '0;
    s_valid  = '0;
    model_reset();
    test_reset();
    test_latency();
    test_back_to_back();
    test_backpressure();
    test_stall_random();
    test_counter();
    test_reset_mid();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
